// File: rtl/exec_alu_branch_unit.sv
// ---------------------------------------------------------------------------
// exec_alu_branch_unit
//
// Integer execute block for the single-cycle RV32I datapath. It holds three
// pieces of logic and one small register stage:
//   - ALU operation decode: ALUOp / funct3 / funct7[5] -> 4-bit control code
//   - 32-bit integer ALU with a zero flag
//   - conditional-branch resolution for PC-next selection
//   - one-stage registered copies of the result and the branch decision,
//     used only for trace and debug
//
// Ports:
//   i_clk              clock; used only by the registered copies
//   i_rst              asynchronous, active-high reset of the registered copies
//   i_ALUOp    [2:0]   operation class from main control
//   i_Funct3   [2:0]   instr[14:12]
//   i_Funct7   [6:0]   instr[31:25]; only bit 5 is used
//   i_Ra       [31:0]  operand A
//   i_Rb       [31:0]  operand B; Rb[4:0] is the shift amount
//   i_Branch           instruction is a conditional branch
//   o_ALUControlLines [3:0]  decoded ALU operation
//   o_Rc       [31:0]  ALU result (combinational)
//   o_Z                o_Rc == 0 (combinational)
//   o_DoBranch         take the branch (combinational)
//   o_Rc_q     [31:0]  o_Rc registered on i_clk
//   o_DoBranch_q       o_DoBranch registered on i_clk
// ---------------------------------------------------------------------------
module exec_alu_branch_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [2:0]      i_ALUOp,
    input  logic [2:0]      i_Funct3,
    input  logic [6:0]      i_Funct7,
    input  logic [XLEN-1:0] i_Ra,
    input  logic [XLEN-1:0] i_Rb,
    input  logic            i_Branch,
    output logic [3:0]      o_ALUControlLines,
    output logic [XLEN-1:0] o_Rc,
    output logic            o_Z,
    output logic            o_DoBranch,
    output logic [XLEN-1:0] o_Rc_q,
    output logic            o_DoBranch_q
);

    // ALU control codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    // ALUOp operation classes
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_RTYPE  = 3'b010;
    localparam logic [2:0] OP_ITYPE  = 3'b011;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            zero_flag;
    logic            branch_cond;
    logic            alt_bit;
    logic [4:0]      shamt;

    // Only funct7[5] selects an alternate operation; the other bits are
    // collected here so they are visibly intentionally unused.
    logic unused_funct7;
    assign unused_funct7 = ^{i_Funct7[6], i_Funct7[4:0]};

    assign alt_bit = i_Funct7[5];
    assign shamt   = i_Rb[4:0];

    // Operation decode. R-type and I-type share the funct3 table; the only
    // difference is that an I-type with funct3=000 is ADDI, which has no SUB
    // form, so funct7[5] is honoured there only for R-type. Branches compare
    // by subtraction (BEQ/BNE) or by set-less-than (BLT/BGE, BLTU/BGEU),
    // chosen from funct3[2:1].
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (i_ALUOp)
            OP_ADD: begin
                alu_ctrl = ALU_ADD;
            end
            OP_BRANCH: begin
                case (i_Funct3[2:1])
                    2'b10:   alu_ctrl = ALU_SLT;
                    2'b11:   alu_ctrl = ALU_SLTU;
                    default: alu_ctrl = ALU_SUB;
                endcase
            end
            OP_RTYPE, OP_ITYPE: begin
                case (i_Funct3)
                    3'b000: begin
                        if ((i_ALUOp == OP_RTYPE) && alt_bit) begin
                            alu_ctrl = ALU_SUB;
                        end else begin
                            alu_ctrl = ALU_ADD;
                        end
                    end
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b011: alu_ctrl = ALU_SLTU;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b101: alu_ctrl = alt_bit ? ALU_SRA : ALU_SRL;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: begin
                alu_ctrl = ALU_ADD;
            end
        endcase
    end

    // Integer ALU. Add/sub wrap modulo 2^XLEN. Compare results are a single
    // bit zero-extended. Unused control codes produce zero.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_result = i_Ra + i_Rb;
            ALU_SUB:  alu_result = i_Ra - i_Rb;
            ALU_SLL:  alu_result = i_Ra << shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(i_Ra) < $signed(i_Rb))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (i_Ra < i_Rb)};
            ALU_XOR:  alu_result = i_Ra ^ i_Rb;
            ALU_SRL:  alu_result = i_Ra >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(i_Ra) >>> shamt);
            ALU_OR:   alu_result = i_Ra | i_Rb;
            ALU_AND:  alu_result = i_Ra & i_Rb;
            default:  alu_result = '0;
        endcase
    end

    assign zero_flag = (alu_result == '0);

    // Branch condition. BEQ/BNE look at the zero flag of the subtraction;
    // the ordered compares look at bit 0 of the SLT/SLTU result. funct3
    // 010/011 are not branch encodings and never take.
    always_comb begin
        branch_cond = 1'b0;
        case (i_Funct3)
            F3_BEQ:  branch_cond = zero_flag;
            F3_BNE:  branch_cond = ~zero_flag;
            F3_BLT:  branch_cond = alu_result[0];
            F3_BGE:  branch_cond = ~alu_result[0];
            F3_BLTU: branch_cond = alu_result[0];
            F3_BGEU: branch_cond = ~alu_result[0];
            default: branch_cond = 1'b0;
        endcase
    end

    assign o_ALUControlLines = alu_ctrl;
    assign o_Rc              = alu_result;
    assign o_Z               = zero_flag;
    assign o_DoBranch        = i_Branch & branch_cond;

    // Trace/debug copies. Reset clears them asynchronously and holds them
    // cleared; the first capture after release is the next rising edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_Rc_q       <= '0;
            o_DoBranch_q <= 1'b0;
        end else begin
            o_Rc_q       <= alu_result;
            o_DoBranch_q <= i_Branch & branch_cond;
        end
    end

endmodule

// File: tb/tb_exec_alu_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_alu_branch_unit
//
// Self-checking bench for exec_alu_branch_unit. Each applied stimulus pushes
// the reference expectation onto a scoreboard queue; checkOutput pops it and
// compares it against the combinational outputs. Spec example values are
// additionally compared against literal constants, and the registered copies
// are checked after clock edges and around asynchronous reset.
// ---------------------------------------------------------------------------
module tb_exec_alu_branch_unit;

    logic        i_clk;
    logic        i_rst;
    logic [2:0]  i_ALUOp;
    logic [2:0]  i_Funct3;
    logic [6:0]  i_Funct7;
    logic [31:0] i_Ra;
    logic [31:0] i_Rb;
    logic        i_Branch;
    logic [3:0]  o_ALUControlLines;
    logic [31:0] o_Rc;
    logic        o_Z;
    logic        o_DoBranch;
    logic [31:0] o_Rc_q;
    logic        o_DoBranch_q;

    typedef struct {
        string       tag;
        logic [3:0]  ctrl;
        logic [31:0] rc;
        logic        z;
        logic        db;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastRc;
    logic        lastDb;

    exec_alu_branch_unit #(.XLEN(32)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_ALUOp           (i_ALUOp),
        .i_Funct3          (i_Funct3),
        .i_Funct7          (i_Funct7),
        .i_Ra              (i_Ra),
        .i_Rb              (i_Rb),
        .i_Branch          (i_Branch),
        .o_ALUControlLines (o_ALUControlLines),
        .o_Rc              (o_Rc),
        .o_Z               (o_Z),
        .o_DoBranch        (o_DoBranch),
        .o_Rc_q            (o_Rc_q),
        .o_DoBranch_q      (o_DoBranch_q)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference decode
    function automatic logic [3:0] modelCtrl(input logic [2:0] op, input logic [2:0] f3, input logic alt);
        logic [3:0] c;
        c = 4'd0;
        if (op == 3'b001) begin
            if (f3 == 3'b100 || f3 == 3'b101)      c = 4'd3;
            else if (f3 == 3'b110 || f3 == 3'b111) c = 4'd4;
            else                                   c = 4'd1;
        end else if (op == 3'b010 || op == 3'b011) begin
            unique case (f3)
                3'd0: c = (op == 3'b010 && alt) ? 4'd1 : 4'd0;
                3'd1: c = 4'd2;
                3'd2: c = 4'd3;
                3'd3: c = 4'd4;
                3'd4: c = 4'd5;
                3'd5: c = alt ? 4'd7 : 4'd6;
                3'd6: c = 4'd8;
                3'd7: c = 4'd9;
            endcase
        end
        return c;
    endfunction

    // Reference ALU
    function automatic logic [31:0] modelAlu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh = int'(b[4:0]);
        case (c)
            4'd0: return a + b;
            4'd1: return a + (~b) + 32'd1;
            4'd2: return a << sh;
            4'd3: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a >> sh;
            4'd7: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Reference branch decision from the reference result
    function automatic logic modelBranch(input logic br, input logic [2:0] f3, input logic [31:0] rc);
        logic cond;
        case (f3)
            3'd0:    cond = (rc == 32'd0);
            3'd1:    cond = (rc != 32'd0);
            3'd4, 3'd6: cond = rc[0];
            3'd5, 3'd7: cond = !rc[0];
            default: cond = 1'b0;
        endcase
        return br && cond;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic br,
                                 input string tag);
        exp_t e;
        i_ALUOp  = op;
        i_Funct3 = f3;
        i_Funct7 = f7;
        i_Ra     = a;
        i_Rb     = b;
        i_Branch = br;
        e.tag  = tag;
        e.ctrl = modelCtrl(op, f3, f7[5]);
        e.rc   = modelAlu(e.ctrl, a, b);
        e.z    = (e.rc == 32'd0);
        e.db   = modelBranch(br, f3, e.rc);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        checkVal({e.tag, "_ctrl"}, {28'd0, o_ALUControlLines}, {28'd0, e.ctrl});
        checkVal({e.tag, "_rc"},   o_Rc, e.rc);
        checkVal({e.tag, "_z"},    {31'd0, o_Z}, {31'd0, e.z});
        checkVal({e.tag, "_db"},   {31'd0, o_DoBranch}, {31'd0, e.db});
        lastRc = e.rc;
        lastDb = e.db;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        $display("[TB] start");

        // Reset state and reset independence of the combinational path
        i_rst = 1'b1;
        applyStimulus(3'b000, 3'b000, 7'h00, 32'd3, 32'd4, 1'b0, "add_3_4");
        #1;
        checkVal("rst_rc_q", o_Rc_q, 32'd0);
        checkVal("rst_db_q", {31'd0, o_DoBranch_q}, 32'd0);
        checkOutput();
        checkVal("rst_comb_rc", o_Rc, 32'd7);
        @(posedge i_clk); #1;
        checkVal("rst_held_rc_q", o_Rc_q, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        checkVal("reg_rc_q_7", o_Rc_q, 32'd7);
        checkVal("reg_db_q_0", {31'd0, o_DoBranch_q}, 32'd0);

        // Registered branch decision, then async reset between edges
        @(negedge i_clk);
        applyStimulus(3'b001, 3'b000, 7'h00, 32'd5, 32'd5, 1'b1, "reg_beq");
        #1 checkOutput();
        @(posedge i_clk); #1;
        checkVal("reg_db_q_1", {31'd0, o_DoBranch_q}, 32'd1);
        applyStimulus(3'b010, 3'b110, 7'h00, 32'hF0, 32'h0F, 1'b0, "reg_or");
        @(posedge i_clk); #1;
        checkVal("reg_rc_q_ff", o_Rc_q, 32'hFF);
        checkOutput();
        #2 i_rst = 1'b1;
        #1;
        checkVal("async_rst_rc_q", o_Rc_q, 32'd0);
        checkVal("async_rst_db_q", {31'd0, o_DoBranch_q}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Decode sweep over every ALUOp x funct3 x funct7[5]
        for (int op = 0; op < 8; op++) begin
            for (int f3 = 0; f3 < 8; f3++) begin
                for (int alt = 0; alt < 2; alt++) begin
                    applyStimulus(3'(op), 3'(f3), alt[0] ? 7'h20 : 7'h00,
                                  $urandom, $urandom, 1'($urandom_range(0, 1)), "sweep");
                    #1 checkOutput();
                end
            end
        end
        applyStimulus(3'b010, 3'b000, 7'h20, 32'd9, 32'd2, 1'b0, "ex_rsub");
        #1 checkOutput();
        checkVal("ex_rsub_code", {28'd0, o_ALUControlLines}, 32'd1);
        applyStimulus(3'b011, 3'b000, 7'h20, 32'd9, 32'd2, 1'b0, "ex_iadd");
        #1 checkOutput();
        checkVal("ex_iadd_code", {28'd0, o_ALUControlLines}, 32'd0);
        applyStimulus(3'b011, 3'b101, 7'h20, 32'd9, 32'd2, 1'b0, "ex_isra");
        #1 checkOutput();
        checkVal("ex_isra_code", {28'd0, o_ALUControlLines}, 32'd7);

        // Arithmetic edges
        applyStimulus(3'b000, 3'b000, 7'h00, 32'hFFFFFFFF, 32'd1, 1'b0, "add_wrap");
        #1 checkOutput();
        checkVal("add_wrap_rc", o_Rc, 32'd0);
        checkVal("add_wrap_z", {31'd0, o_Z}, 32'd1);
        applyStimulus(3'b010, 3'b000, 7'h20, 32'd0, 32'd1, 1'b0, "sub_0_1");
        #1 checkOutput();
        checkVal("sub_0_1_rc", o_Rc, 32'hFFFFFFFF);
        applyStimulus(3'b010, 3'b010, 7'h00, 32'h80000000, 32'd1, 1'b0, "slt_min");
        #1 checkOutput();
        checkVal("slt_min_rc", o_Rc, 32'd1);
        applyStimulus(3'b010, 3'b011, 7'h00, 32'h80000000, 32'd1, 1'b0, "sltu_min");
        #1 checkOutput();
        checkVal("sltu_min_rc", o_Rc, 32'd0);

        // Shifts
        applyStimulus(3'b010, 3'b101, 7'h20, 32'h80000000, 32'd31, 1'b0, "sra31");
        #1 checkOutput();
        checkVal("sra31_rc", o_Rc, 32'hFFFFFFFF);
        applyStimulus(3'b010, 3'b101, 7'h00, 32'h80000000, 32'd31, 1'b0, "srl31");
        #1 checkOutput();
        checkVal("srl31_rc", o_Rc, 32'd1);
        applyStimulus(3'b010, 3'b001, 7'h00, 32'd1, 32'h21, 1'b0, "sll_wrap");
        #1 checkOutput();
        checkVal("sll_wrap_rc", o_Rc, 32'd2);

        // Branches
        applyStimulus(3'b001, 3'b000, 7'h00, 32'd5, 32'd5, 1'b1, "beq_eq");
        #1 checkOutput();
        checkVal("beq_eq_db", {31'd0, o_DoBranch}, 32'd1);
        applyStimulus(3'b001, 3'b001, 7'h00, 32'd5, 32'd5, 1'b1, "bne_eq");
        #1 checkOutput();
        checkVal("bne_eq_db", {31'd0, o_DoBranch}, 32'd0);
        applyStimulus(3'b001, 3'b100, 7'h00, 32'hFFFFFFFF, 32'd0, 1'b1, "blt_m1");
        #1 checkOutput();
        checkVal("blt_m1_db", {31'd0, o_DoBranch}, 32'd1);
        applyStimulus(3'b001, 3'b110, 7'h00, 32'hFFFFFFFF, 32'd0, 1'b1, "bltu_max");
        #1 checkOutput();
        checkVal("bltu_max_db", {31'd0, o_DoBranch}, 32'd0);
        applyStimulus(3'b001, 3'b111, 7'h00, 32'hFFFFFFFF, 32'd0, 1'b1, "bgeu_max");
        #1 checkOutput();
        checkVal("bgeu_max_db", {31'd0, o_DoBranch}, 32'd1);
        applyStimulus(3'b001, 3'b101, 7'h00, 32'd3, 32'd3, 1'b1, "bge_eq");
        #1 checkOutput();
        checkVal("bge_eq_db", {31'd0, o_DoBranch}, 32'd1);
        applyStimulus(3'b001, 3'b010, 7'h00, 32'd5, 32'd5, 1'b1, "f3_010");
        #1 checkOutput();
        checkVal("f3_010_db", {31'd0, o_DoBranch}, 32'd0);
        applyStimulus(3'b001, 3'b000, 7'h00, 32'd5, 32'd5, 1'b0, "nobranch");
        #1 checkOutput();
        checkVal("nobranch_db", {31'd0, o_DoBranch}, 32'd0);

        // Random ops/operands; each step also checks the registered copies
        for (int i = 0; i < 10000; i++) begin
            @(negedge i_clk);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          7'($urandom_range(0, 127)), a, b, 1'($urandom_range(0, 1)), "rand");
            #1 checkOutput();
            @(posedge i_clk); #1;
            checkVal("rand_rc_q", o_Rc_q, lastRc);
            checkVal("rand_db_q", {31'd0, o_DoBranch_q}, {31'd0, lastDb});
        end

        checkVal("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_alu_branch_unit.md
# exec_alu_branch_unit

Integer execute block for the single-cycle RV32I datapath. It combines three functions: ALU operation decode (ALUOp/funct3/funct7 → 4-bit control lines), the 32-bit integer ALU with zero flag, and conditional-branch resolution. Its combinational outputs feed the data-memory address, the write-back mux and PC-next selection. It also holds a one-stage registered copy of the result and the branch decision for trace and debug.

## Interface
- XLEN, 32, datapath width; shift amount is i_Rb[4:0]
- i_clk  in  1  clock; only the registered copies use it
- i_rst  in  1  asynchronous, active-high reset
- i_ALUOp  in  3  operation class from main control
- i_Funct3  in  3  instr[14:12]
- i_Funct7  in  7  instr[31:25]; only bit 5 is used
- i_Ra  in  XLEN  operand A
- i_Rb  in  XLEN  operand B
- i_Branch  in  1  instruction is a conditional branch
- o_ALUControlLines  out  4  decoded ALU operation
- o_Rc  out  XLEN  ALU result, combinational
- o_Z  out  1  result equals zero, combinational
- o_DoBranch  out  1  take branch, combinational
- o_Rc_q  out  XLEN  o_Rc registered
- o_DoBranch_q  out  1  o_DoBranch registered

## Operation
- **ALU control codes:**
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - Codes 1010–1111 give o_Rc = 0.
- **ALUOp decode:**
  - 000: ADD (loads, stores, LUI with A=0, AUIPC, JAL/JALR link, CSR).
  - 001 (branch), by funct3[2:1]:
    - 00 → SUB
    - 01 → SUB
    - 10 → SLT
    - 11 → SLTU
  - 010 (R-type), by funct3:
    - 000 → ADD, or SUB if funct7[5]=1
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
    - 101 → SRL, or SRA if funct7[5]=1
    - 110 OR, 111 AND
  - 011 (I-type): same as R-type, except funct3=000 is always ADD (funct7 ignored); funct7[5] applies only to funct3=101.
  - 100–111: ADD.
- **ALU:**
  - ADD/SUB are modulo 2^32 and carry is discarded.
  - SLT is a signed compare; SLTU is unsigned. Both give a 0/1 result zero-extended to 32 bits.
  - Shifts use i_Rb[4:0] only. SRA replicates i_Ra[31].
- **Zero flag:** o_Z = (o_Rc == 0). It is valid for every operation.
- **Branch resolution:** o_DoBranch = i_Branch AND cond, where cond is selected by i_Funct3:
  - 000 BEQ: o_Z
  - 001 BNE: !o_Z
  - 100 BLT: o_Rc[0]
  - 101 BGE: !o_Rc[0]
  - 110 BLTU: o_Rc[0]
  - 111 BGEU: !o_Rc[0]
  - 010 and 011: cond = 0
- When i_Branch = 0, o_DoBranch = 0 regardless of the other inputs.
- The decode is internal, but o_ALUControlLines is exported so verification can observe it.

## Timing
- o_ALUControlLines, o_Rc, o_Z and o_DoBranch are purely combinational, with zero latency from any input. No latches: every path assigns a default.
- On the i_clk rising edge: o_Rc_q ← o_Rc and o_DoBranch_q ← o_DoBranch. Latency is 1 cycle.
- i_rst = 1 asynchronously forces o_Rc_q = 0 and o_DoBranch_q = 0, immediately and for as long as it is held.
- i_rst does not affect the combinational outputs.
- Releasing i_rst mid-operation: the first capture happens at the first rising edge after deassertion.
- There is no handshake and no state machine.

## Test plan
- **Decode sweep:** all ALUOp × funct3 × funct7[5] → expected control code. Examples:
  - ALUOp=010, f3=000, f7=0x20 → 0001
  - ALUOp=011, f3=000, f7=0x20 → 0000
  - ALUOp=011, f3=101, f7=0x20 → 0111
- **Arithmetic edges:**
  - ADD 0xFFFFFFFF+1 → 0, o_Z=1
  - SUB 0−1 → 0xFFFFFFFF
  - SLT 0x80000000,1 → 1
  - SLTU 0x80000000,1 → 0
- **Shifts:**
  - SRA 0x80000000 by 31 → 0xFFFFFFFF
  - SRL same → 1
  - SLL 1 by Rb=0x21 → 2 (only Rb[4:0]=1 is used)
- **Branches:**
  - BEQ with Ra=Rb=5 → DoBranch=1
  - BNE with Ra=Rb=5 → 0
  - BLT −1,0 → 1
  - BLTU 0xFFFFFFFF,0 → 0
  - BGEU 0xFFFFFFFF,0 → 1
  - f3=010 → 0
  - i_Branch=0 with equal operands → 0
- **Registers:**
  - Drive ADD 3+4 → o_Rc_q=7 after one edge.
  - Assert i_rst between edges → o_Rc_q and o_DoBranch_q drop to 0 without waiting for a clock edge.
- **Random:** 10k random operands and ops compared against a reference model, including o_Z and o_DoBranch.
